word_serializer: RTL

Parametrised word-to-byte serializer for the UART transmit path. It accepts a word of WORD_BYTES bytes over a valid/ready handshake and emits its bytes one per accepted beat over a second valid/ready handshake, in a configurable byte order. It sits between word-producing logic and the UART byte transmitter. It replaces the fixed 16-bit, two-byte, handshake-less splitter with proper backpressure, back-to-back words and a clock enable.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/word_serializer_if.sv | 30 +++
 rtl/word_hold_reg.sv | 40 ++++
 rtl/word_serializer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit-path definitions: byte width, serializer FSM states,
// and the counter-width helper used by word_serializer.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // ceil(log2(n)) with a floor of 1 so a one-byte word still has a counter bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = 32'(i + 1);
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Handshake bundle for word_serializer.
//   ce                    : clock enable qualifying both handshakes
//   in_valid/in_ready     : word input handshake, in_word payload
//   out_valid/out_ready   : byte output handshake, out_byte payload
//   busy                  : a word is held or still being sent
// master = word producer / byte consumer side, slave = the serializer.
interface word_serializer_if
    import uart_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 2
);
    logic                           ce;
    logic                           in_valid;
    logic                           in_ready;
    logic [BYTE_W*WORD_BYTES-1:0]   in_word;
    logic                           out_valid;
    logic                           out_ready;
    logic [BYTE_W-1:0]              out_byte;
    logic                           busy;

    modport master (
        output ce, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_byte, busy
    );

    modport slave (
        input  ce, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_byte, busy
    );
endinterface

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register.
//   i_ce               : clock enable; nothing moves while low
//   i_valid/o_ready    : write side; o_ready is registered (!full)
//   o_valid/i_ready    : read side; o_valid is the full flag
//   i_data/o_data      : payload
module word_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // A full entry must drain before it can refill, keeping o_ready registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_ce) begin
            if (r_full) begin
                if (i_ready) r_full <= 1'b0;
            end else if (i_valid) begin
                r_full <= 1'b1;
                r_data <= i_data;
            end
        end
    end

    assign o_ready = ~r_full;
    assign o_valid = r_full;
    assign o_data  = r_data;
endmodule

// File: rtl/word_serializer.sv
// Word-to-byte serializer for the UART transmit path.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : word_serializer_if slave (ce, word in, byte out, busy)
// Parameters: WORD_BYTES (1..8) bytes per word, MSB_FIRST byte order.
// Build option WORD_SERIALIZER_SKID_EN adds a one-word holding register so
// in_ready is registered instead of combinational from out_ready.
module word_serializer
    import uart_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    word_serializer_if.slave        bus
);
    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
    localparam int unsigned CNT_W  = clog2_min1(WORD_BYTES);

    ser_state_t         r_state, w_state_nxt;
    logic [WORD_W-1:0]  r_shift, w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic               w_last;
    logic               w_out_hs;
    logic               w_load;
    logic [WORD_W-1:0]  w_src_word;
    logic [WORD_W-1:0]  w_shifted;

    assign w_last    = (r_cnt == CNT_W'(WORD_BYTES - 1));
    assign w_out_hs  = bus.out_valid & bus.out_ready & bus.ce;
    assign w_shifted = MSB_FIRST ? (r_shift << BYTE_W) : (r_shift >> BYTE_W);

`ifdef WORD_SERIALIZER_SKID_EN
    logic              w_take;
    logic              w_hold_push;
    logic              w_hold_valid;
    logic              w_hold_ready;
    logic [WORD_W-1:0] w_hold_word;

    // Serializer can take a new word this cycle
    assign w_take = bus.ce & ((r_state == IDLE) | (w_last & w_out_hs));
    // Empty hold plus a free serializer bypasses the hold so latency matches the plain build
    assign w_hold_push = bus.in_valid & ~(w_take & ~w_hold_valid);

    word_hold_reg #(
        .WIDTH (WORD_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (bus.ce),
        .i_valid (w_hold_push),
        .o_ready (w_hold_ready),
        .i_data  (bus.in_word),
        .o_valid (w_hold_valid),
        .i_ready (w_take),
        .o_data  (w_hold_word)
    );

    assign bus.in_ready = w_hold_ready;
    assign w_src_word   = w_hold_valid ? w_hold_word : bus.in_word;
    assign w_load       = w_take & (w_hold_valid | bus.in_valid);
    assign bus.busy     = (r_state == SEND) | w_hold_valid;
`else
    // Accept while idle, or when the last byte leaves this same cycle
    assign bus.in_ready = (r_state == IDLE) | (w_last & bus.out_ready);
    assign w_src_word   = bus.in_word;
    assign w_load       = bus.in_valid & bus.in_ready & bus.ce;
    assign bus.busy     = (r_state == SEND);
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: load, shift per accepted byte, reload or drain on the last byte
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_shift_nxt = w_src_word;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_out_hs) begin
                    if (w_last) begin
                        w_cnt_nxt = '0;
                        if (w_load) begin
                            w_shift_nxt = w_src_word;
                        end else begin
                            w_shift_nxt = w_shifted;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.out_valid = (r_state == SEND);
    assign bus.out_byte  = MSB_FIRST ? r_shift[WORD_W-1 -: BYTE_W] : r_shift[BYTE_W-1:0];
endmodule
